// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: the 32-bit machine word and the RAM responder
// handshake state seen by every requester on the memory port.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/ram_array.sv
// DEPTH x 32 word store: one synchronous write port and one registered
// read port. Only the read-data register is cleared by RST.
module ram_array
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH = 16384,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  word_t         wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output word_t         rdata
);

  word_t mem [DEPTH];

  // Write port: commit one word when the controller strobes we.
  // NOTE: the storage array has no reset branch; clearing thousands of words
  // would defeat RAM inference and the contents must survive RST anyway.
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: capture the addressed word, hold it until the next read.
  always_ff @(posedge CLK) begin
    if (RST)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ram_ctrl.sv
// RAM responder with a LAT-cycle BUSY phase ahead of each one-cycle ACCESS.
// Requests are level-held; a changed request during BUSY restarts the wait,
// a dropped request aborts it, and both ramREN and ramWEN high gives ERROR.
// Optional feature: define RAM_ADDRCHK_EN to send requests addressed at or
// beyond 4*DEPTH bytes to ERROR; otherwise the word index wraps modulo DEPTH.
module ram_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 16384
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  output word_t     ramload,
  output ramstate_t ramstate
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = 4;

  logic [CNT_W-1:0] cnt;
  logic             lat_wen;
  word_t            lat_addr;
  word_t            lat_data;

  logic      req_any;
  logic      req_both;
  logic      changed;
  logic      addr_ok;
  logic      load_req;
  logic      commit;
  ramstate_t acc_state;

`ifdef RAM_ADDRCHK_EN
  assign addr_ok = (ramaddr[31:AW+2] == '0);
`else
  assign addr_ok = 1'b1;
`endif

  // Decode the current request against the latched one and pick the state an
  // accept would move to.
  // NOTE: every output of this block gets a default first so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    req_any   = ramREN | ramWEN;
    req_both  = ramREN & ramWEN;
    changed   = (ramWEN != lat_wen) || (ramaddr != lat_addr) || (ramstore != lat_data);
    acc_state = FREE;
    if (req_both)      acc_state = ERROR;
    else if (!req_any) acc_state = FREE;
    else if (!addr_ok) acc_state = ERROR;
    else               acc_state = BUSY;
    load_req = 1'b0;
    if (acc_state == BUSY) begin
      if (ramstate inside {FREE, ACCESS}) load_req = 1'b1;
      else if (ramstate == BUSY)          load_req = changed;
    end
    commit = (ramstate == BUSY) && !RST && req_any && !req_both && !changed && (cnt == '0);
  end

  // Responder FSM with latched request and latency counter.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ramstate <= FREE;
      cnt      <= '0;
      lat_wen  <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
    end else begin
      if (load_req) begin
        cnt      <= CNT_W'(LAT - 1);
        lat_wen  <= ramWEN;
        lat_addr <= ramaddr;
        lat_data <= ramstore;
      end
      unique case (ramstate)
        FREE, ACCESS: ramstate <= acc_state;
        BUSY: begin
          if (req_both || !req_any || changed) ramstate <= acc_state;
          else if (cnt != '0)                  cnt      <= cnt - CNT_W'(1);
          else                                 ramstate <= ACCESS;
        end
        ERROR:        ramstate <= FREE;
        default:      ramstate <= FREE;
      endcase
    end
  end

  ram_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_array (
    .CLK  (CLK),
    .RST  (RST),
    .we   (commit & lat_wen),
    .waddr(lat_addr[AW+1:2]),
    .wdata(lat_data),
    .re   (commit & ~lat_wen),
    .raddr(lat_addr[AW+1:2]),
    .rdata(ramload)
  );

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl: a transaction-level model tracks the
// expected responder state, memory image and ramload; a compare process
// checks the DUT every cycle, and directed scenarios pin literal values.
module tb_ram_ctrl;
  import cpu_types_pkg::*;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;

  logic      clk;
  logic      rst;
  logic      ren;
  logic      wen;
  word_t     addr;
  word_t     store;
  word_t     ramload;
  ramstate_t ramstate;

  int n_tests = 0;
  int n_fail  = 0;

  ram_ctrl #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .CLK     (clk),
    .RST     (rst),
    .ramREN  (ren),
    .ramWEN  (wen),
    .ramaddr (addr),
    .ramstore(store),
    .ramload (ramload),
    .ramstate(ramstate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic  wen;
    word_t a;
    word_t d;
  } txn_t;

  ramstate_t m_state = FREE;
  int        m_left  = 0;     // BUSY cycles still to spend, current one included
  txn_t      m_pend  = '0;
  word_t     m_mem [DEPTH];
  word_t     m_load  = '0;

  task model_accept();
    if (ren && wen) m_state = ERROR;
    else if (ren || wen) begin
      m_pend  = '{wen: wen, a: addr, d: store};
      m_left  = LAT;
      m_state = BUSY;
    end else m_state = FREE;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_state = FREE;
      m_load  = '0;
      m_pend  = '0;
    end else begin
      case (m_state)
        ERROR: m_state = FREE;
        BUSY: begin
          if (ren && wen)          m_state = ERROR;
          else if (!ren && !wen)   m_state = FREE;
          else if (wen != m_pend.wen || addr != m_pend.a || store != m_pend.d) model_accept();
          else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
              m_state = ACCESS;
              if (m_pend.wen) m_mem[m_pend.a[AW+1:2]] = m_pend.d;
              else            m_load = m_mem[m_pend.a[AW+1:2]];
            end
          end
        end
        default: model_accept();
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("model_state", 32'(ramstate), 32'(m_state));
    check("model_load", ramload, m_load);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic w, input word_t a, input word_t d);
    ren = r; wen = w; addr = a; store = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0);
  endtask

  task automatic lit(input string name, input ramstate_t s, input logic chk_load, input word_t ld);
    check({name, "_state"}, 32'(ramstate), 32'(s));
    if (chk_load) check({name, "_load"}, ramload, ld);
  endtask

  initial begin
    int p;
    rst = 1'b1;
    idle();
    repeat (2) step();
    lit("reset", FREE, 1'b1, 32'h0);
    rst = 1'b0;

    // Fill every word with a known pattern through the normal interface.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, word_t'(i * 4), 32'hA500_0000 | word_t'(i));
      repeat (LAT + 1) step();
    end
    idle();
    step();
    lit("preload_done", FREE, 1'b0, '0);

    // Write 0x40 then read it back; read held across two accesses.
    drive(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF);
    step(); lit("wr40_c1", BUSY, 1'b0, '0);
    step(); lit("wr40_c2", BUSY, 1'b0, '0);
    step(); lit("wr40_c3", ACCESS, 1'b0, '0);
    idle();
    step(); lit("wr40_c4", FREE, 1'b0, '0);
    drive(1'b1, 1'b0, 32'h40, 32'h0);
    step(); lit("rd40_c1", BUSY, 1'b0, '0);
    step(); lit("rd40_c2", BUSY, 1'b0, '0);
    step(); lit("rd40_c3", ACCESS, 1'b1, 32'hDEAD_BEEF);
    step(); lit("rd40_c4", BUSY, 1'b1, 32'hDEAD_BEEF);
    step(); lit("rd40_c5", BUSY, 1'b0, '0);
    step(); lit("rd40_c6", ACCESS, 1'b1, 32'hDEAD_BEEF);
    step(); lit("rd40_c7", BUSY, 1'b0, '0);
    idle();
    step(); lit("rd40_abort", FREE, 1'b1, 32'hDEAD_BEEF);

    // Aborted write to 0x80 leaves old contents.
    drive(1'b0, 1'b1, 32'h80, 32'h1234_5678);
    step(); lit("ab80_c1", BUSY, 1'b0, '0);
    step(); lit("ab80_c2", BUSY, 1'b0, '0);
    idle();
    step(); lit("ab80_c3", FREE, 1'b0, '0);
    drive(1'b1, 1'b0, 32'h80, 32'h0);
    repeat (LAT + 1) step();
    lit("rd80", ACCESS, 1'b1, 32'hA500_0020);
    idle();
    step();

    // Both requests high -> one ERROR cycle, array untouched.
    drive(1'b1, 1'b1, 32'h40, 32'h0);
    step(); lit("both_err", ERROR, 1'b1, 32'hA500_0020);
    idle();
    step(); lit("both_free", FREE, 1'b0, '0);
    drive(1'b1, 1'b0, 32'h40, 32'h0);
    repeat (LAT + 1) step();
    lit("both_rd40", ACCESS, 1'b1, 32'hDEAD_BEEF);
    idle();
    step();

    // Reset during BUSY cancels a write to 0x10.
    drive(1'b0, 1'b1, 32'h10, 32'hCAFE_F00D);
    step(); lit("rst10_c1", BUSY, 1'b0, '0);
    rst = 1'b1;
    idle();
    step(); lit("rst10_after", FREE, 1'b1, 32'h0);
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h10, 32'h0);
    repeat (LAT + 1) step();
    lit("rd10", ACCESS, 1'b1, 32'hA500_0004);

    // Out-of-range write wraps to word 0 (accepted straight from ACCESS).
    drive(1'b0, 1'b1, 32'(4 * DEPTH), 32'h0BAD_CAFE);
    repeat (LAT + 1) step();
    lit("wrap_wr", ACCESS, 1'b1, 32'hA500_0004);
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    repeat (LAT + 1) step();
    lit("wrap_rd0", ACCESS, 1'b1, 32'h0BAD_CAFE);
    idle();
    step();

    // Retarget in BUSY restarts the full latency at the new address.
    drive(1'b0, 1'b1, 32'h20, 32'h1111_1111);
    step(); lit("rt_c1", BUSY, 1'b0, '0);
    drive(1'b0, 1'b1, 32'h24, 32'h1111_1111);
    step(); lit("rt_c2", BUSY, 1'b0, '0);
    step(); lit("rt_c3", BUSY, 1'b0, '0);
    step(); lit("rt_c4", ACCESS, 1'b0, '0);
    drive(1'b1, 1'b0, 32'h20, 32'h0);
    repeat (LAT + 1) step();
    lit("rt_rd20", ACCESS, 1'b1, 32'hA500_0008);
    drive(1'b1, 1'b0, 32'h24, 32'h0);
    repeat (LAT + 1) step();
    lit("rt_rd24", ACCESS, 1'b1, 32'h1111_1111);
    idle();
    step();

    // Randomised traffic: long holds, new requests, drops, conflicts, resets.
    for (int c = 0; c < 4000; c++) begin
      rst = 1'b0;
      p = int'($urandom_range(0, 99));
      if (p < 60) begin
        // keep current inputs
      end else if (p < 76) begin
        logic w;
        word_t a;
        w = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) a = $urandom;
        else a = word_t'($urandom_range(0, DEPTH - 1) * 4);
        drive(~w, w, a, $urandom);
      end else if (p < 86) idle();
      else if (p < 89) drive(1'b1, 1'b1, addr, store);
      else if (p < 91) rst = 1'b1;
      else if (p < 95) store = $urandom;
      else addr = word_t'($urandom_range(0, DEPTH - 1) * 4);
      step();
    end
    rst = 1'b0;
    idle();
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
